// File: rtl/accum_sequencer_if.sv
// Handshake and datapath-strobe bundle between the requesting units,
// the accumulator sequencer and the accumulator datapath.
interface accum_sequencer_if;
   logic [1:0] REQ;
   logic [1:0] CLR_REQ;
   logic       OVERFLOW;
   logic [1:0] GNT;
   logic       ZERO;
   logic       LOAD;
   logic       ADD;
   logic       STORE;
   logic [1:0] ACK;
   logic       ERR;
   logic       BUSY;
   logic [6:0] STATE;

   // REQ[i] is a level request held until the ACK[i] pulse; the requester
   // drops it on the edge that ends the ACK[i] cycle, otherwise it counts as new.
   modport master (
      output REQ, CLR_REQ, OVERFLOW,
      input  GNT, ZERO, LOAD, ADD, STORE, ACK, ERR, BUSY, STATE
   );

   modport slave (
      input  REQ, CLR_REQ, OVERFLOW,
      output GNT, ZERO, LOAD, ADD, STORE, ACK, ERR, BUSY, STATE
   );
endinterface

// File: rtl/accum_sequencer.sv
// Round-robin arbiter plus one-hot sequencer that drives the shared
// accumulator through clear/load/add/check/store with bounded overflow retry.
module accum_sequencer #(
   parameter int MAX_RETRY = 1
) (
   input logic              CLK,
   input logic              RESET,
   accum_sequencer_if.slave bus
);

   typedef enum logic [6:0] {
      S_IDLE  = 7'b0000001,
      S_ZERO  = 7'b0000010,
      S_LOAD  = 7'b0000100,
      S_ADD   = 7'b0001000,
      S_CHECK = 7'b0010000,
      S_STORE = 7'b0100000,
      S_DONE  = 7'b1000000
   } state_t;

   localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

   state_t     state_q;
   logic       ptr_q;
   logic       win_q;
   logic [1:0] retry_q;
   logic       fail_q;
   logic [1:0] gnt_q;
   logic       zero_q;
   logic       load_q;
   logic       add_q;
   logic       store_q;
   logic [1:0] ack_q;
   logic       err_q;
   logic       busy_q;
   logic       win_d;

   // A lone request wins outright; the pointer only breaks ties.
   assign win_d = (bus.REQ == 2'b11) ? ptr_q : bus.REQ[1];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         retry_q <= 2'd0;
         fail_q  <= 1'b0;
         gnt_q   <= 2'b00;
         zero_q  <= 1'b0;
         load_q  <= 1'b0;
         add_q   <= 1'b0;
         store_q <= 1'b0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         zero_q  <= 1'b0;
         load_q  <= 1'b0;
         add_q   <= 1'b0;
         store_q <= 1'b0;
         ack_q   <= 2'b00;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.REQ != 2'b00) begin
                  win_q   <= win_d;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  retry_q <= 2'd0;
                  fail_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  if (bus.CLR_REQ[win_d]) begin
                     state_q <= S_ZERO;
                     zero_q  <= 1'b1;
                  end else begin
                     state_q <= S_LOAD;
                     load_q  <= 1'b1;
                  end
               end
            end
            S_ZERO: begin
               state_q <= S_LOAD;
               load_q  <= 1'b1;
            end
            S_LOAD: begin
               state_q <= S_ADD;
               add_q   <= 1'b1;
            end
            S_ADD: begin
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (!bus.OVERFLOW) begin
                  state_q <= S_STORE;
                  store_q <= 1'b1;
               end else if (retry_q < MAX_R) begin
                  // A retry restarts from a cleared accumulator regardless of CLR_REQ.
                  retry_q <= retry_q + 2'd1;
                  state_q <= S_ZERO;
                  zero_q  <= 1'b1;
               end else begin
                  fail_q  <= 1'b1;
                  state_q <= S_DONE;
                  ack_q   <= gnt_q;
                  err_q   <= 1'b1;
               end
            end
            S_STORE: begin
               state_q <= S_DONE;
               ack_q   <= gnt_q;
               err_q   <= fail_q;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               ptr_q   <= ~win_q;
               gnt_q   <= 2'b00;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= 2'b00;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.GNT   = gnt_q;
   assign bus.ZERO  = zero_q;
   assign bus.LOAD  = load_q;
   assign bus.ADD   = add_q;
   assign bus.STORE = store_q;
   assign bus.ACK   = ack_q;
   assign bus.ERR   = err_q;
   assign bus.BUSY  = busy_q;
   assign bus.STATE = state_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: one DUT with MAX_RETRY=1, one with MAX_RETRY=0;
// ACK/ERR timing is checked against a per-DUT expected queue.
module tb_accum_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [15:0] cyc;

   // Entry layout: {ACK[1:0], ERR, cycle number of the ACK}
   logic [18:0] exp_q0[$];
   logic [18:0] exp_q1[$];

   accum_sequencer_if b0();
   accum_sequencer_if b1();

   accum_sequencer #(.MAX_RETRY(1)) dut0 (.CLK(clk), .RESET(rst), .bus(b0));
   accum_sequencer #(.MAX_RETRY(0)) dut1 (.CLK(clk), .RESET(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle, sample 1ns after the edge, and retire any ACKs.
   task automatic tick();
      logic [18:0] e;
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (!$onehot0({b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}) || !$onehot0(b0.GNT)) begin
         errors++;
         $display("FAIL onehot0 cyc=%0d strobes=%b gnt=%b", cyc,
                  {b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}, b0.GNT);
      end
      if (b0.ACK !== 2'b00) begin
         checks++;
         if (exp_q0.size() == 0) begin
            errors++;
            $display("FAIL ack0_spurious cyc=%0d ack=%b required none", cyc, b0.ACK);
         end else begin
            e = exp_q0.pop_front();
            if ({b0.ACK, b0.ERR, cyc} !== e) begin
               errors++;
               $display("FAIL ack0 got ack=%b err=%b cyc=%0d required ack=%b err=%b cyc=%0d",
                        b0.ACK, b0.ERR, cyc, e[18:17], e[16], e[15:0]);
            end
         end
      end
      if (b1.ACK !== 2'b00) begin
         checks++;
         if (exp_q1.size() == 0) begin
            errors++;
            $display("FAIL ack1_spurious cyc=%0d ack=%b required none", cyc, b1.ACK);
         end else begin
            e = exp_q1.pop_front();
            if ({b1.ACK, b1.ERR, cyc} !== e) begin
               errors++;
               $display("FAIL ack1 got ack=%b err=%b cyc=%0d required ack=%b err=%b cyc=%0d",
                        b1.ACK, b1.ERR, cyc, e[18:17], e[16], e[15:0]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({b0.GNT, b0.ZERO, b0.LOAD, b0.ADD, b0.STORE, b0.ACK, b0.ERR, b0.BUSY} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%b required=0", {b0.GNT, b0.ZERO, b0.LOAD,
                  b0.ADD, b0.STORE, b0.ACK, b0.ERR, b0.BUSY});
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({b0.BUSY, b1.BUSY, b0.GNT, b1.GNT} !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle busy0=%b busy1=%b gnt0=%b gnt1=%b required 0",
                  b0.BUSY, b1.BUSY, b0.GNT, b1.GNT);
      end
   endtask

   task automatic test_basic();
      logic [3:0] tbl[6];
      logic [15:0] c0;
      tbl = '{4'b0100, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      b0.REQ = 2'b01; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b0;
      c0 = cyc;
      exp_q0.push_back({2'b01, 1'b0, 16'(c0 + 16'd5)});
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if ({b0.ZERO, b0.LOAD, b0.ADD, b0.STORE} !== tbl[k-1] ||
             b0.GNT !== ((k <= 5) ? 2'b01 : 2'b00) || b0.BUSY !== (k <= 5)) begin
            errors++;
            $display("FAIL basic k=%0d strobes=%b gnt=%b busy=%b required strobes=%b",
                     k, {b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}, b0.GNT, b0.BUSY, tbl[k-1]);
         end
         if (k == 5) b0.REQ = 2'b00;
      end
   endtask

   task automatic test_clear();
      logic [3:0] tbl[6];
      logic [15:0] c0;
      tbl = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
      b0.REQ = 2'b10; b0.CLR_REQ = 2'b10; b0.OVERFLOW = 1'b0;
      c0 = cyc;
      exp_q0.push_back({2'b10, 1'b0, 16'(c0 + 16'd6)});
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if ({b0.ZERO, b0.LOAD, b0.ADD, b0.STORE} !== tbl[k-1] || b0.GNT !== 2'b10) begin
            errors++;
            $display("FAIL clear k=%0d strobes=%b gnt=%b required strobes=%b gnt=10",
                     k, {b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}, b0.GNT, tbl[k-1]);
         end
         if (k == 6) begin
            b0.REQ = 2'b00; b0.CLR_REQ = 2'b00;
         end
      end
      tick();
   endtask

   task automatic test_contention();
      logic        w;
      logic [1:0]  oh;
      logic [15:0] c0;
      w = 1'b0;
      b0.REQ = 2'b11; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b0;
      for (int t = 0; t < 4; t++) begin
         oh = w ? 2'b10 : 2'b01;
         c0 = cyc;
         exp_q0.push_back({oh, 1'b0, 16'(c0 + 16'd5)});
         for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (b0.GNT !== oh) begin
               errors++;
               $display("FAIL contention t=%0d k=%0d gnt=%b required=%b", t, k, b0.GNT, oh);
            end
         end
         b0.REQ = ~oh;
         tick();
         checks++;
         if (b0.BUSY !== 1'b0 || b0.GNT !== 2'b00) begin
            errors++;
            $display("FAIL contention_gap t=%0d busy=%b gnt=%b required 0 00", t, b0.BUSY, b0.GNT);
         end
         b0.REQ = 2'b11;
         w = ~w;
      end
      b0.REQ = 2'b00;
      tick();
   endtask

   task automatic test_retry_ok();
      logic [3:0] tbl[9];
      logic [15:0] c0;
      tbl = '{4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
      b0.REQ = 2'b01; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b0;
      c0 = cyc;
      exp_q0.push_back({2'b01, 1'b0, 16'(c0 + 16'd9)});
      for (int k = 1; k <= 9; k++) begin
         tick();
         checks++;
         if ({b0.ZERO, b0.LOAD, b0.ADD, b0.STORE} !== tbl[k-1]) begin
            errors++;
            $display("FAIL retry_ok k=%0d strobes=%b required=%b",
                     k, {b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}, tbl[k-1]);
         end
         b0.OVERFLOW = (k == 3);
         if (k == 9) b0.REQ = 2'b00;
      end
      tick();
   endtask

   task automatic test_fail();
      logic [3:0] tbl[8];
      logic [15:0] c0;
      tbl = '{4'b0100, 4'b0010, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
      b0.REQ = 2'b01; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b1;
      c0 = cyc;
      exp_q0.push_back({2'b01, 1'b1, 16'(c0 + 16'd8)});
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if ({b0.ZERO, b0.LOAD, b0.ADD, b0.STORE} !== tbl[k-1]) begin
            errors++;
            $display("FAIL fail_r1 k=%0d strobes=%b required=%b",
                     k, {b0.ZERO, b0.LOAD, b0.ADD, b0.STORE}, tbl[k-1]);
         end
         if (k == 8) begin
            b0.REQ = 2'b00; b0.OVERFLOW = 1'b0;
         end
      end
      tick();
      b1.REQ = 2'b10; b1.CLR_REQ = 2'b00; b1.OVERFLOW = 1'b1;
      c0 = cyc;
      exp_q1.push_back({2'b10, 1'b1, 16'(c0 + 16'd4)});
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (b1.STORE !== 1'b0 || b1.BUSY !== (k <= 4)) begin
            errors++;
            $display("FAIL fail_r0 k=%0d store=%b busy=%b required store=0 busy=%b",
                     k, b1.STORE, b1.BUSY, (k <= 4));
         end
         if (k == 4) begin
            b1.REQ = 2'b00; b1.OVERFLOW = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] c0;
      b0.REQ = 2'b01; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b0;
      tick();
      tick();
      checks++;
      if (b0.ADD !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_add add=%b required=1", b0.ADD);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({b0.GNT, b0.ZERO, b0.LOAD, b0.ADD, b0.STORE, b0.ACK, b0.ERR, b0.BUSY} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid_async got=%b required=0", {b0.GNT, b0.ZERO, b0.LOAD,
                  b0.ADD, b0.STORE, b0.ACK, b0.ERR, b0.BUSY});
      end
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b0;
      b0.REQ = 2'b11;
      c0 = cyc;
      exp_q0.push_back({2'b01, 1'b0, 16'(c0 + 16'd5)});
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            checks++;
            if (b0.GNT !== 2'b01) begin
               errors++;
               $display("FAIL reset_mid_grant gnt=%b required=01", b0.GNT);
            end
         end
         if (k == 5) b0.REQ = 2'b00;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 16'd0;
      rst = 1'b1;
      b0.REQ = 2'b00; b0.CLR_REQ = 2'b00; b0.OVERFLOW = 1'b0;
      b1.REQ = 2'b00; b1.CLR_REQ = 2'b00; b1.OVERFLOW = 1'b0;
      test_reset();
      test_basic();
      test_clear();
      test_contention();
      test_retry_ok();
      test_fail();
      test_reset_mid();
      for (int k = 0; k < 3; k++) tick();
      checks++;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         errors++;
         $display("FAIL ack_missing pending0=%0d pending1=%0d required 0 0",
                  exp_q0.size(), exp_q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
